fifo_router: RTL and testbench
==============================

# fifo_router

Per-destination packet FIFO of the router. It buffers bytes from the router's write path and tags the header byte of each packet with a first-byte marker. When a header is read out, it tracks the remaining payload and parity bytes, and puts the output into an idle state once the whole packet has been drained. There is one instance per output port, between the router FSM/synchronizer and the output port.

## Interface
- DEPTH, 16: number of entries (power of two).
- WIDTH, 8: data byte width; each stored word is WIDTH+1 bits (bit WIDTH = header marker).
- clock  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- soft_reset  in  1  synchronous flush (timeout recovery), active-high.
- write_enb  in  1  write request for data_in.
- read_enb  in  1  read request.
- lfd_state  in  1  "load first data" from the router FSM; marks the next written byte as a header.
- data_in  in  8  byte to store.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- data_out  out  8  registered read data.

## Operation
- Storage: DEPTH × (WIDTH+1) memory. Write pointer and read pointer are each log2(DEPTH)+1 bits; the extra MSB disambiguates full from empty.
- lfd register: lfd_q <= lfd_state every cycle. A word written in cycle N stores {lfd_q, data_in}, so the header marker is lfd_state from cycle N-1.
- Write: if write_enb && !full, mem[wr_ptr] <= {lfd_q, data_in} and wr_ptr increments (wraps modulo 2·DEPTH). Writes while full are dropped silently.
- Read: if read_enb && !empty, data_out <= mem[rd_ptr][7:0] and rd_ptr increments. Reads while empty are ignored.
- Packet counter (6 bits):
  - On a read of a word whose marker is set: count <= word[7:2] + 1, i.e. payload length plus parity.
  - On a read of an unmarked word with count != 0: count decrements.
- Idle output: in a cycle with no read and count == 0, data_out <= IDLE (see Configuration). Otherwise data_out holds.
- Simultaneous read and write are both performed in the same cycle, including when full or empty: full blocks only the write, empty blocks only the read.
- Priority: resetn > soft_reset > read/write.
- soft_reset clears both pointers, count and lfd_q, and sets data_out to IDLE. Memory contents are not cleared; they are logically discarded.
- resetn low clears the pointers, count, lfd_q and all memory words, and sets data_out to 8'h00.
- full = (wr_ptr[MSB] != rd_ptr[MSB]) && (low bits equal). empty = (wr_ptr == rd_ptr).

## Timing
- Reset values: data_out = 8'h00, full = 0, empty = 1.
- full and empty are combinational from the registered pointers. They update in the cycle after the causing edge.
- Read latency is 1 cycle: data_out is valid after the edge at which read_enb && !empty was sampled.
- The header written one cycle after lfd_state is high is the byte that carries the marker.
- Pointer wrap at DEPTH entries is seamless.
- soft_reset or resetn asserted mid-packet abandons the packet. The next marked word restarts counting.

## Configuration
- FIFO_ROUTER_TRISTATE_EN
  - Defined: IDLE = 8'hzz. data_out floats after soft_reset and at the end of a packet, for the shared-bus output.
  - Undefined: IDLE = 8'h00, with no tri-state drivers.
  - Reset value under resetn is 8'h00 in both builds.

## Structure
- Shared router package:
  - ROUTER_DATA_W = 8.
  - ROUTER_FIFO_DEPTH = 16.
  - Header field positions: addr = [1:0], payload length = [7:2].
  - The IDLE value constant.
- No sub-module: memory, pointers and counter are flat in fifo_router.

## Test plan
- Reset: drive resetn low for 1 cycle → empty = 1, full = 0, data_out = 8'h00.
- Header marking and counting:
  - Stimulus: lfd_state high for 1 cycle, then write header 8'h25 (len 9, addr 01), 9 payload bytes and 1 parity byte.
  - Then read 11 words with read_enb held high.
  - Expected: bytes appear in order with 1-cycle latency. count loads 10 on the header and reaches 0 after the parity byte. The next idle cycle drives IDLE.
- Full: write 20 words with no reads → full asserts after the 16th write, words 17–20 are dropped, and reads return the first 16 only.
- Empty read: read_enb high while empty → pointers unchanged, empty stays 1, data_out stays at IDLE.
- Simultaneous access:
  - With 16 words stored, read and write in the same cycle → read occurs, write is dropped, and full deasserts.
  - With 8 words stored, read and write in the same cycle → occupancy stays 8.
- Soft reset mid-packet: assert soft_reset after 5 reads of an 11-byte packet → empty = 1, data_out = IDLE. A new header packet then reads back correctly.

Source files
------------

// File: rtl/fifo_router_pkg.sv
// Shared router definitions: data width, FIFO depth, header field
// positions and the value an output port drives while idle.
// Optional build macro: FIFO_ROUTER_TRISTATE_EN (idle output floats).
package fifo_router_pkg;

  localparam int unsigned ROUTER_DATA_W     = 8;
  localparam int unsigned ROUTER_FIFO_DEPTH = 16;

  // Header byte layout
  localparam int unsigned ROUTER_ADDR_LSB = 0;
  localparam int unsigned ROUTER_ADDR_MSB = 1;
  localparam int unsigned ROUTER_LEN_LSB  = 2;
  localparam int unsigned ROUTER_LEN_MSB  = 7;
  localparam int unsigned ROUTER_LEN_W    = ROUTER_LEN_MSB - ROUTER_LEN_LSB + 1;

`ifdef FIFO_ROUTER_TRISTATE_EN
  localparam logic [ROUTER_DATA_W-1:0] ROUTER_IDLE = 8'hzz;
`else
  localparam logic [ROUTER_DATA_W-1:0] ROUTER_IDLE = 8'h00;
`endif

endpackage

// File: rtl/fifo_router.sv
// Per-destination packet FIFO. Stores {header marker, byte}, tracks the
// remaining bytes of the packet being drained and idles the output once
// the packet is complete.
// Optional build macro: FIFO_ROUTER_TRISTATE_EN (idle output floats).
module fifo_router
  import fifo_router_pkg::*;
#(
  parameter int unsigned DEPTH = ROUTER_FIFO_DEPTH,
  parameter int unsigned WIDTH = ROUTER_DATA_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data_out
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned CNT_W  = ROUTER_LEN_W;

  logic [WIDTH:0]   mem_q [DEPTH];
  logic [WIDTH:0]   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             lfd_q, lfd_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0]   rd_word;
  logic             do_wr, do_rd;
`ifdef FIFO_ROUTER_TRISTATE_EN
  logic             float_q, float_d;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

`ifdef FIFO_ROUTER_TRISTATE_EN
  // Idle is held as a separate float flag so no 'z' is ever stored in a flop.
  assign data_out = float_q ? ROUTER_IDLE : data_out_q;
`else
  assign data_out = data_out_q;
`endif

  // Next-state: flush, then independent write and read, packet counting and idling.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    lfd_d      = lfd_state;
    data_out_d = data_out_q;
`ifdef FIFO_ROUTER_TRISTATE_EN
    float_d    = float_q;
`endif
    do_wr      = write_enb && !full;
    do_rd      = read_enb && !empty;
    rd_word    = mem_q[rd_ptr_q[ADDR_W-1:0]];

    if (soft_reset) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      lfd_d    = 1'b0;
`ifdef FIFO_ROUTER_TRISTATE_EN
      data_out_d = '0;
      float_d    = 1'b1;
`else
      data_out_d = ROUTER_IDLE;
`endif
    end else begin
      if (do_wr) begin
        mem_d[wr_ptr_q[ADDR_W-1:0]] = {lfd_q, data_in};
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (do_rd) begin
        data_out_d = rd_word[WIDTH-1:0];
`ifdef FIFO_ROUTER_TRISTATE_EN
        float_d    = 1'b0;
`endif
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        if (rd_word[WIDTH]) begin
          // payload length plus the trailing parity byte
          count_d = rd_word[ROUTER_LEN_MSB:ROUTER_LEN_LSB] + CNT_W'(1);
        end else if (count_q != '0) begin
          count_d = count_q - CNT_W'(1);
        end
      end else if (count_q == '0) begin
`ifdef FIFO_ROUTER_TRISTATE_EN
        data_out_d = '0;
        float_d    = 1'b1;
`else
        data_out_d = ROUTER_IDLE;
`endif
      end
    end
  end

  // State registers; power-on reset also clears the storage array.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lfd_q      <= 1'b0;
      data_out_q <= '0;
`ifdef FIFO_ROUTER_TRISTATE_EN
      float_q    <= 1'b0;
`endif
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lfd_q      <= lfd_d;
      data_out_q <= data_out_d;
`ifdef FIFO_ROUTER_TRISTATE_EN
      float_q    <= float_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_router.sv
// Self-checking bench for fifo_router: directed scenarios plus random
// traffic, compared every cycle against a queue-based packet model.
module tb_fifo_router;

  localparam int DEPTH = 16;

`ifdef FIFO_ROUTER_TRISTATE_EN
  localparam logic [7:0] IDLE_V = 8'hzz;
`else
  localparam logic [7:0] IDLE_V = 8'h00;
`endif

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       read_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = '0;
  logic       full;
  logic       empty;
  logic [7:0] data_out;

  fifo_router #(.DEPTH(16), .WIDTH(8)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .write_enb  (write_enb),
    .read_enb   (read_enb),
    .lfd_state  (lfd_state),
    .data_in    (data_in),
    .full       (full),
    .empty      (empty),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  // Reference model: queue of {marker, byte}, remaining packet bytes, output byte
  logic [8:0] m_q[$];
  int         m_cnt;
  logic       m_lfd;
  logic [7:0] m_dout;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".empty"}, {7'd0, empty}, {7'd0, m_q.size() == 0});
    check_eq({tag, ".full"},  {7'd0, full},  {7'd0, m_q.size() == DEPTH});
    check_eq({tag, ".data"},  data_out, m_dout);
  endtask

  // One clock: apply inputs, advance the model by the behavioural rules, compare.
  task automatic step(input logic sr, input logic we, input logic re,
                      input logic lfd, input logic [7:0] din, input string tag);
    logic [8:0] w;
    bit         rd, wr;
    soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    @(posedge clock);
    if (sr) begin
      m_q.delete();
      m_cnt  = 0;
      m_lfd  = 1'b0;
      m_dout = IDLE_V;
    end else begin
      rd = re && (m_q.size() != 0);
      wr = we && (m_q.size() != DEPTH);
      if (rd) begin
        w = m_q.pop_front();
        m_dout = w[7:0];
        if (w[8]) m_cnt = (int'(w[7:2]) + 1) % 64;
        else if (m_cnt != 0) m_cnt--;
      end else if (m_cnt == 0) begin
        m_dout = IDLE_V;
      end
      if (wr) m_q.push_back({m_lfd, din});
      m_lfd = lfd;
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_cycle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, tag);
  endtask

  // Header announced by lfd one cycle early, then header, payload, parity.
  task automatic write_packet(input logic [7:0] hdr, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, {tag, ".lfd"});
    step(1'b0, 1'b1, 1'b0, 1'b0, hdr, {tag, ".hdr"});
    for (int i = 0; i < int'(hdr[7:2]) + 1; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), {tag, ".pay"});
  endtask

  initial begin
    m_cnt = 0; m_lfd = 1'b0; m_dout = 8'h00;

    // Asynchronous reset
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    check_eq("rst.empty", {7'd0, empty}, 8'd1);
    check_eq("rst.full",  {7'd0, full},  8'd0);
    check_eq("rst.data",  data_out,      8'h00);
    @(posedge clock); #1;
    resetn = 1'b1;
    check_outputs("rst.post");

    // Header marking and packet counting: 8'h25 = len 9, addr 01
    write_packet(8'h25, "pkt");
    check_eq("pkt.empty", {7'd0, empty}, 8'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "pkt.rd");
    check_eq("pkt.hdr_out", data_out, 8'h25);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "pkt.rd");
    check_eq("pkt.drained", {7'd0, empty}, 8'd1);
    idle_cycle("pkt.idle");
    check_eq("pkt.idle_out", data_out, IDLE_V);

    // Full: 20 writes, last 4 dropped, 16 read back
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i), "full.wr");
      if (i == 14) check_eq("full.at15", {7'd0, full}, 8'd0);
      if (i == 15) check_eq("full.at16", {7'd0, full}, 8'd1);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "full.rd");
      check_eq("full.order", data_out, 8'(8'h40 + i));
    end
    check_eq("full.empty", {7'd0, empty}, 8'd1);

    // Empty read
    idle_cycle("empty.idle");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "empty.rd");
    check_eq("empty.data", data_out, IDLE_V);

    // Simultaneous access when full, then at 8 words
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'(8'h80 + i), "sim.fill");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hEE, "sim.full_rw");
    check_eq("sim.full_drop", {7'd0, full}, 8'd0);
    check_eq("sim.full_rd", data_out, 8'h80);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "sim.drain");
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'hA5, "sim.half_rw");
    check_eq("sim.occ8", 8'(m_q.size()), 8'd8);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "sim.drain2");
    check_eq("sim.last", data_out, 8'hA5);

    // Soft reset mid-packet, then a fresh packet
    write_packet(8'h25, "srst.pkt");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "srst.rd");
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, "srst.flush");
    check_eq("srst.empty", {7'd0, empty}, 8'd1);
    check_eq("srst.data", data_out, IDLE_V);
    write_packet(8'h0A, "srst.new");
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "srst.new_rd");
    check_eq("srst.new_hdr", data_out, 8'h0A);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, "srst.new_rd");
    idle_cycle("srst.new_idle");

    // Random traffic with occasional headers and flushes
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 8),
           8'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
